// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue
//  Description : Circular queue of pending register-file writes. Accepted
//                requests drain to the register file in acceptance order, one
//                per cycle, unless drain_hold is asserted. Two read ports are
//                checked against all pending entries for hazard detection.
//                Optional macro WBQ_BYPASS_EN adds newest-match data outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_wa,
    input  logic [31:0]              in_wd,
    input  logic                     drain_hold,
    output logic                     we,
    output logic [4:0]               wa,
    output logic [31:0]              wd,
    input  logic [4:0]               ra0,
    input  logic [4:0]               ra1,
    output logic                     pend0,
    output logic                     pend1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
`ifdef WBQ_BYPASS_EN
    ,
    output logic [31:0]              byp0_data,
    output logic [31:0]              byp1_data
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [4:0]          r_wa_mem [DEPTH];
    logic [31:0]         r_wd_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_PTR_W:0]    r_count;

    logic                w_push;
    logic                w_pop;
    logic [c_PTR_W-1:0]  w_scan_idx;

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = (r_count == (c_PTR_W+1)'(DEPTH));
    assign in_ready = !full && !reset;
    assign we       = !empty && !drain_hold;
    assign wa       = empty ? 5'd0  : r_wa_mem[r_head];
    assign wd       = empty ? 32'd0 : r_wd_mem[r_head];

    // Writes to address 0 complete the handshake but are never stored.
    assign w_push   = in_valid && in_ready && (in_wa != 5'd0);
    assign w_pop    = we;

    // Entry storage: intentionally not cleared by reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_wa_mem[r_tail] <= in_wa;
            r_wd_mem[r_tail] <= in_wd;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan valid entries oldest-to-newest; the last hit is the newest match.
    always_comb begin
        pend0      = 1'b0;
        pend1      = 1'b0;
        w_scan_idx = '0;
`ifdef WBQ_BYPASS_EN
        byp0_data  = 32'd0;
        byp1_data  = 32'd0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_head + k[c_PTR_W-1:0];
            if (k[c_PTR_W:0] < r_count) begin
                if ((ra0 != 5'd0) && (r_wa_mem[w_scan_idx] == ra0)) begin
                    pend0 = 1'b1;
`ifdef WBQ_BYPASS_EN
                    byp0_data = r_wd_mem[w_scan_idx];
`endif
                end
                if ((ra1 != 5'd0) && (r_wa_mem[w_scan_idx] == ra1)) begin
                    pend1 = 1'b1;
`ifdef WBQ_BYPASS_EN
                    byp1_data = r_wd_mem[w_scan_idx];
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire
